// File: rtl/jpeg_rx_pkg.sv
// Shared JPEG marker bytes and the start/end-of-image filter state encoding.
package jpeg_rx_pkg;

  localparam logic [7:0] SOI_B0 = 8'hFF;
  localparam logic [7:0] SOI_B1 = 8'hD8;
  localparam logic [7:0] EOI_B1 = 8'hD9;

  typedef enum logic [1:0] {
    IDLE,
    SOI_FF,
    IN_FRAME,
    EOI_FF
  } state_t;

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock byte FIFO with registered read; accepts a write while full
// when a read frees the head slot on the same edge.
module rx_sync_fifo #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;
  logic [CW-1:0] count_next;

  always_comb begin
    do_rd      = rd_en && !empty;
    do_wr      = wr_en && (!full || do_rd);
    drop_c     = wr_en && full && !do_rd;
    count_next = count + CW'(do_wr) - CW'(do_rd);
  end

  // When full both pointers alias; the read sees the old head before the write lands.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      count <= count_next;
      empty <= (count_next == CW'(0));
      full  <= (count_next == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/jpeg_rx_buffer.sv
// UART receive byte buffer with error/overflow accounting. Defining
// JPEG_RX_FILTER_EN adds an SOI/EOI filter so only JPEG frames are stored.
module jpeg_rx_buffer
  import jpeg_rx_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 64,
  localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_avail,
  input  logic                  rx_error,
  input  logic                  rd_en,
  input  logic                  ovf_clr,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic [7:0]            err_cnt,
  output logic                  frame_active,
  output logic                  frame_done,
  output logic [7:0]            frame_cnt
);

  logic       wr_en_c;
  logic [7:0] wr_data_c;
  logic       err_inc_c;
  logic       drop_c;

`ifdef JPEG_RX_FILTER_EN
  state_t state;
  logic   pending;
  logic   accept_c;

  // A strobe landing on the deferred D8 write cycle is counted as an error.
  always_comb begin
    accept_c  = rx_avail && !rx_error && !pending;
    err_inc_c = rx_avail && (rx_error || pending);
    wr_en_c   = 1'b0;
    wr_data_c = rx_data;
    if (pending) begin
      wr_en_c   = 1'b1;
      wr_data_c = SOI_B1;
    end else if (accept_c) begin
      case (state)
        IDLE:    wr_en_c = 1'b0;
        SOI_FF: begin
          if (rx_data == SOI_B1) begin
            wr_en_c   = 1'b1;
            wr_data_c = SOI_B0;
          end
        end
        default: wr_en_c = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      pending    <= 1'b0;
      if (accept_c) begin
        case (state)
          IDLE: if (rx_data == SOI_B0) state <= SOI_FF;
          SOI_FF: begin
            if (rx_data == SOI_B1) begin
              state        <= IN_FRAME;
              pending      <= 1'b1;
              frame_active <= 1'b1;
            end else if (rx_data != SOI_B0) begin
              state <= IDLE;
            end
          end
          IN_FRAME: if (rx_data == SOI_B0) state <= EOI_FF;
          EOI_FF: begin
            if (rx_data == EOI_B1) begin
              state        <= IDLE;
              frame_active <= 1'b0;
              frame_done   <= 1'b1;
              frame_cnt    <= frame_cnt + 8'd1;
            end else if (rx_data != SOI_B0) begin
              state <= IN_FRAME;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`else
  always_comb begin
    err_inc_c = rx_avail && rx_error;
    wr_en_c   = rx_avail && !rx_error;
    wr_data_c = rx_data;
  end

  assign frame_active = 1'b0;
  assign frame_done   = 1'b0;
  assign frame_cnt    = 8'h00;
`endif

  // Sticky overflow: a drop on the clearing cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (err_inc_c && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (drop_c)       overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  rx_sync_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_c),
    .wr_data (wr_data_c),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .drop_c  (drop_c)
  );

endmodule

// File: tb/tb_jpeg_rx_buffer.sv
// Bench for jpeg_rx_buffer (depth 4); follows JPEG_RX_FILTER_EN when defined.
module tb_jpeg_rx_buffer;

  localparam int unsigned DEPTH = 4;
`ifdef JPEG_RX_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_error;
  logic       rd_en;
  logic       ovf_clr;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] err_cnt;
  logic       frame_active;
  logic       frame_done;
  logic [7:0] frame_cnt;

  int n_pass = 0;
  int n_total = 0;
  int fd_pulses = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         stored;
    int         exp_count;
    int         exp_err;
    bit         drain;
  } vec_t;
  vec_t vt[$];

  always #5 clk = ~clk;

  jpeg_rx_buffer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_avail     (rx_avail),
    .rx_error     (rx_error),
    .rd_en        (rd_en),
    .ovf_clr      (ovf_clr),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .err_cnt      (err_cnt),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) fd_pulses++;
  endtask

  // One strobe then one idle cycle; stored = bytes this strobe should enqueue.
  task automatic send(input logic [7:0] b, input logic err, input int stored);
    rx_data  = b;
    rx_error = err;
    rx_avail = 1'b1;
    tick();
    rx_avail = 1'b0;
    rx_error = 1'b0;
    tick();
    if (stored == 2) begin
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hD8);
    end else if (stored == 1) begin
      exp_q.push_back(b);
    end
  endtask

  task automatic read_chk(input string name);
    logic [7:0] e;
    e = exp_q.pop_front();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk(name, int'(rd_data), int'(e));
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) read_chk(name);
    chk({name, " empty"}, int'(empty), 1);
  endtask

  // Inputs stay busy during reset to show reset overrides them.
  task automatic do_reset();
    reset    = 1'b1;
    rx_avail = 1'b1;
    rx_error = 1'b0;
    rx_data  = 8'hFF;
    rd_en    = 1'b1;
    ovf_clr  = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    rx_avail = 1'b0;
    rd_en    = 1'b0;
    exp_q.delete();
    fd_pulses = 0;
  endtask

  task automatic enter_frame();
    if (FILT) begin
      send(8'hFF, 1'b0, 0);
      send(8'hD8, 1'b0, 2);
    end
  endtask

  initial begin
    logic [7:0] e;
    int k;
    reset = 1'b1; rx_data = 8'h00; rx_avail = 1'b0; rx_error = 1'b0;
    rd_en = 1'b0; ovf_clr = 1'b0;

`ifdef JPEG_RX_FILTER_EN
    vt.push_back('{8'h12, 1'b0, 0, 0, 0, 1'b0});
    vt.push_back('{8'hFF, 1'b0, 0, 0, 0, 1'b0});
    vt.push_back('{8'hD8, 1'b0, 2, 2, 0, 1'b0});
    vt.push_back('{8'hAA, 1'b0, 1, 3, 0, 1'b1});
    vt.push_back('{8'hFF, 1'b0, 1, 1, 0, 1'b0});
    vt.push_back('{8'hD9, 1'b0, 1, 2, 0, 1'b0});
    vt.push_back('{8'h34, 1'b0, 0, 2, 0, 1'b1});
`else
    vt.push_back('{8'h12, 1'b0, 1, 1, 0, 1'b0});
    vt.push_back('{8'h55, 1'b1, 0, 1, 1, 1'b0});
    vt.push_back('{8'hFF, 1'b0, 1, 2, 1, 1'b0});
    vt.push_back('{8'hD8, 1'b0, 1, 3, 1, 1'b1});
`endif

    do_reset();
    chk("rst empty", int'(empty), 1);
    chk("rst full", int'(full), 0);
    chk("rst count", int'(count), 0);
    chk("rst rd_data", int'(rd_data), 0);
    chk("rst overflow", int'(overflow), 0);
    chk("rst err_cnt", int'(err_cnt), 0);
    chk("rst frame_cnt", int'(frame_cnt), 0);
    chk("rst frame_done", int'(frame_done), 0);
    chk("rst frame_active", int'(frame_active), 0);

    for (int i = 0; i < vt.size(); i++) begin
      send(vt[i].data, vt[i].err, vt[i].stored);
      chk($sformatf("vec%0d count", i), int'(count), vt[i].exp_count);
      chk($sformatf("vec%0d err_cnt", i), int'(err_cnt), vt[i].exp_err);
      if (vt[i].drain) drain($sformatf("vec%0d drain", i));
    end
    chk("table frame_cnt", int'(frame_cnt), FILT ? 1 : 0);
    chk("table frame_done pulses", fd_pulses, FILT ? 1 : 0);
    chk("table frame_active", int'(frame_active), 0);

    // Fill to full, then one dropped write.
    do_reset();
    enter_frame();
    chk("frame_active in frame", int'(frame_active), FILT ? 1 : 0);
    k = 0;
    while (exp_q.size() < DEPTH) begin
      send(8'(16 + k), 1'b0, 1);
      k++;
    end
    chk("fill full pre", int'(full), 1);
    chk("fill overflow pre", int'(overflow), 0);
    send(8'h77, 1'b0, 0);
    chk("ovf full", int'(full), 1);
    chk("ovf count", int'(count), 4);
    chk("ovf flag", int'(overflow), 1);

    // Clear coinciding with a drop keeps overflow set.
    rx_data = 8'h88; rx_avail = 1'b1; ovf_clr = 1'b1;
    tick();
    rx_avail = 1'b0; ovf_clr = 1'b0;
    tick();
    chk("ovf clr+drop", int'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf cleared", int'(overflow), 0);
    chk("ovf clr count", int'(count), 4);

    // Write and read together while full.
    e = exp_q.pop_front();
    rx_data = 8'h99; rx_avail = 1'b1; rd_en = 1'b1;
    tick();
    rx_avail = 1'b0; rd_en = 1'b0;
    exp_q.push_back(8'h99);
    chk("full rw rd_data", int'(rd_data), int'(e));
    chk("full rw count", int'(count), 4);
    tick();
    chk("full rw overflow", int'(overflow), 0);
    drain("full rw drain");

    // Read while empty holds rd_data.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("empty rd hold", int'(rd_data), 8'h99);
    chk("empty rd count", int'(count), 0);

    // Write and read together while empty: write only.
    rx_data = 8'h42; rx_avail = 1'b1; rd_en = 1'b1;
    tick();
    rx_avail = 1'b0; rd_en = 1'b0;
    exp_q.push_back(8'h42);
    chk("empty rw count", int'(count), 1);
    chk("empty rw rd_data", int'(rd_data), 8'h99);
    tick();
    drain("empty rw drain");

    // Error strobes and saturation.
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h00, 1'b1, 0);
    chk("err3 err_cnt", int'(err_cnt), 3);
    chk("err3 count", int'(count), 0);
    for (int i = 0; i < 297; i++) send(8'(i), 1'b1, 0);
    chk("err300 err_cnt", int'(err_cnt), 255);

    // Reset mid-frame abandons contents and frame.
    do_reset();
    send(8'hFF, 1'b0, FILT ? 0 : 1);
    send(8'hD8, 1'b0, FILT ? 2 : 1);
    send(8'h55, 1'b0, 1);
    chk("midframe count", int'(count), 3);
    do_reset();
    chk("midrst empty", int'(empty), 1);
    chk("midrst frame_active", int'(frame_active), 0);
    send(8'h55, 1'b0, FILT ? 0 : 1);
    chk("midrst 55 count", int'(count), FILT ? 0 : 1);

    // Reset on the cycle after D8 cancels the deferred write.
    do_reset();
    send(8'hFF, 1'b0, 0);
    rx_data = 8'hD8; rx_avail = 1'b1;
    tick();
    rx_avail = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("pend cancel count", int'(count), 0);
    chk("pend cancel active", int'(frame_active), 0);

`ifdef JPEG_RX_FILTER_EN
    // Back-to-back strobe during the deferred D8 write is dropped as an error.
    do_reset();
    send(8'hFF, 1'b0, 0);
    rx_data = 8'hD8; rx_avail = 1'b1;
    tick();
    rx_data = 8'h33;
    tick();
    rx_avail = 1'b0;
    tick();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD8);
    chk("b2b err_cnt", int'(err_cnt), 1);
    chk("b2b count", int'(count), 2);
    chk("b2b active", int'(frame_active), 1);
    drain("b2b drain");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jpeg_rx_buffer.md
JPEG_RX_BUFFER -- requirements
Module: jpeg_rx_buffer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64: number of byte entries; power of two, >= 4.
REQ-002 SHALL have derived localparam ADDR_WIDTH = log2(FIFO_DEPTH); it is not overridable.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8: byte from the UART receiver.
REQ-006 SHALL have port rx_avail, input, 1: one-cycle strobe meaning rx_data is valid.
REQ-007 SHALL have port rx_error, input, 1: framing error qualifying the same strobe.
REQ-008 SHALL have port rd_en, input, 1: read request.
REQ-009 SHALL have port ovf_clr, input, 1: clears the overflow flag.
REQ-010 SHALL have port rd_data, output, 8: read byte, registered.
REQ-011 SHALL have port empty, output, 1, and port full, output, 1: FIFO status.
REQ-012 SHALL have port count, output, ADDR_WIDTH+1: current occupancy.
REQ-013 SHALL have port overflow, output, 1: sticky, set when a write is dropped.
REQ-014 SHALL have port err_cnt, output, 8: saturating count of rx_error strobes.
REQ-015 SHALL have port frame_active, output, 1: high between SOI and EOI.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse on the cycle after EOI is accepted.
REQ-017 SHALL have port frame_cnt, output, 8: completed frames, wraps at 255 -> 0.

Function
REQ-018 SHALL accept a byte on a rising edge where rx_avail=1 and rx_error=0; when rx_avail=1 and rx_error=1 it SHALL drop the byte and increment err_cnt, saturating at 255.
REQ-019 SHALL write an accepted byte on the same edge; count, empty and full SHALL reflect the write on the next cycle.
REQ-020 SHALL, when rd_en=1 and empty=0, present the head byte on rd_data one cycle later; rd_en=1 with empty=1 SHALL be ignored and rd_data held.
REQ-021 SHALL, on a write while full with rd_en=1 on the same cycle, accept both and leave count unchanged; on a write while full with rd_en=0, drop the byte and set overflow.
REQ-022 SHALL, on a simultaneous write and read while empty, perform the write and ignore the read.
REQ-023 SHALL wrap read and write pointers modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH.
REQ-024 SHALL clear overflow on ovf_clr=1 unless a drop occurs in the same cycle, in which case overflow SHALL remain set.
REQ-025 SHALL require rx_avail strobes at least 2 cycles apart; a strobe arriving while a pending SOI write is outstanding SHALL be dropped and SHALL increment err_cnt.

Configuration
REQ-026 SHALL, when macro JPEG_RX_FILTER_EN is defined, gate writes with an FSM of states IDLE, SOI_FF, IN_FRAME and EOI_FF.
REQ-027 SHALL implement the IDLE state as: byte FF -> SOI_FF; any other byte is discarded.
REQ-028 SHALL implement the SOI_FF state as: D8 -> IN_FRAME, writing FF now and D8 on the next cycle (the pending write); FF -> stay in SOI_FF; any other byte -> IDLE, nothing written.
REQ-029 SHALL implement the IN_FRAME state as: every byte written; FF -> EOI_FF.
REQ-030 SHALL implement the EOI_FF state as: byte written; D9 -> IDLE with frame_done pulse and frame_cnt+1; FF -> stay in EOI_FF; any other byte -> IN_FRAME.
REQ-031 SHALL assert frame_active in IN_FRAME and EOI_FF; an overflow mid-frame SHALL drop bytes without leaving the frame.
REQ-032 SHALL, without JPEG_RX_FILTER_EN, write every accepted byte, omit the FSM, and tie frame_active, frame_done and frame_cnt to 0.

Reset
REQ-033 SHALL, on reset, clear pointers and count, set empty=1, full=0, rd_data=00, overflow=0, err_cnt=0, frame_cnt=0, frame_done=0, and FSM=IDLE.
REQ-034 SHALL, on reset mid-frame, abandon the frame, discard FIFO contents and cancel any pending D8; reset SHALL override all simultaneous inputs.

Structure
REQ-035 SHALL place marker constants SOI_B0=FF, SOI_B1=D8 and EOI_B1=D9, plus the FSM state enum, in shared package jpeg_rx_pkg.
REQ-036 SHALL implement storage as sub-module rx_sync_fifo (single clock, parametrised depth, registered read); the filter FSM and counters SHALL reside in jpeg_rx_buffer.

Verification
REQ-037 SHALL cover: with filter enabled, bytes 12 FF D8 AA FF D9 34 -> FIFO holds FF D8 AA FF D9, frame_done pulses once, frame_cnt=1.
REQ-038 SHALL cover: with FIFO_DEPTH=4, 5 writes with no reads -> full=1, count=4, overflow=1; ovf_clr -> overflow=0, contents unchanged.
REQ-039 SHALL cover: while full, a write and rd_en on the same cycle -> count stays 4, rd_data=first byte, new byte becomes the tail.
REQ-040 SHALL cover: 3 strobes with rx_error=1 -> err_cnt=3, count=0; 300 error strobes -> err_cnt=255.
REQ-041 SHALL cover: reset asserted after FF D8 55 -> empty=1, frame_active=0; a following 55 is discarded.
REQ-042 SHALL cover: with filter disabled, bytes 12 FF D8 -> all 3 stored, frame_cnt=0.
